rr_arbiter_4: RTL and testbench

//  4-requester round-robin arbiter with grant hold, release handshake and hold timeout.

---
 rtl/rr_arbiter_4_pkg.sv | 37 +++
 rtl/rr_arbiter_4_if.sv | 29 ++
 rtl/rr_arbiter_4_decoder_2x4.sv | 19 +
 rtl/rr_arbiter_4.sv | 98 +++++++++
 tb/tb_rr_arbiter_4.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/rr_arbiter_4_pkg.sv
// rr_arbiter_4_pkg
//   Shared constants, state encoding and the rotating-priority helper used by
//   the 4-requester round-robin arbiter and its one-hot decoder.
package rr_arbiter_4_pkg;

   localparam int NUM_REQ = 4;
   localparam int IDX_W   = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1
   } state_e;

   // Hold counter width: $clog2(max_hold), never below 1 bit so the counter
   // still exists (unused) when the timeout is disabled.
   function automatic int hold_w(input int max_hold);
      return (max_hold <= 2) ? 1 : $clog2(max_hold);
   endfunction

   // First set request bit scanning ptr, ptr+1, ... wrapping mod NUM_REQ.
   // The 2-bit candidate wraps naturally. Result is meaningless when req==0.
   function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                input logic [IDX_W-1:0]   ptr);
      logic [IDX_W-1:0] cand;
      logic             found;
      rr_pick = ptr;
      found   = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = ptr + IDX_W'(i);
         if (!found && req[cand]) begin
            rr_pick = cand;
            found   = 1'b1;
         end
      end
   endfunction

endpackage

// File: rtl/rr_arbiter_4_if.sv
// rr_arbiter_4_if
//   Request/grant bundle between four agents and the arbiter.
//   req[3:0]        agent request vector (level)
//   done            current holder releases the resource
//   gnt_valid       a grant is active
//   gnt_idx[1:0]    current holder, 0 when idle
//   gnt_onehot[3:0] one-hot of gnt_idx, 0 when idle
//   timeout         one-cycle pulse on hold-limit forced release
//   master: agent side, slave: arbiter side.
interface rr_arbiter_4_if;

   logic [rr_arbiter_4_pkg::NUM_REQ-1:0] req;
   logic                                 done;
   logic                                 gnt_valid;
   logic [rr_arbiter_4_pkg::IDX_W-1:0]   gnt_idx;
   logic [rr_arbiter_4_pkg::NUM_REQ-1:0] gnt_onehot;
   logic                                 timeout;

   modport master (
      output req, done,
      input  gnt_valid, gnt_idx, gnt_onehot, timeout
   );

   modport slave (
      input  req, done,
      output gnt_valid, gnt_idx, gnt_onehot, timeout
   );

endinterface

// File: rtl/rr_arbiter_4_decoder_2x4.sv
// rr_arbiter_4_decoder_2x4
//   2-to-4 one-hot decoder with enable.
//   idx[1:0]     index to expand
//   en           output forced to zero when low
//   onehot[3:0]  decoded vector
module rr_arbiter_4_decoder_2x4
   import rr_arbiter_4_pkg::*;
(
   input  logic [IDX_W-1:0]   idx,
   input  logic               en,
   output logic [NUM_REQ-1:0] onehot
);

   always_comb begin
      onehot = '0;
      if (en) onehot[idx] = 1'b1;
   end

endmodule

// File: rtl/rr_arbiter_4.sv
// rr_arbiter_4
//   4-requester round-robin arbiter with grant hold, done/drop release and an
//   optional hold-limit timeout. Grant index and valid are registered; the
//   one-hot vector is a gated decode of the registered index, so no input
//   reaches an output combinationally.
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   rr_arbiter_4_if slave modport (req/done in, grant outputs)
//   MAX_HOLD  max consecutive grant cycles before forced release, 0 = none
module rr_arbiter_4
   import rr_arbiter_4_pkg::*;
#(
   parameter int MAX_HOLD = 8
) (
   input  logic            clk,
   input  logic            rst,
   rr_arbiter_4_if.slave   bus
);

   localparam int HCW = hold_w(MAX_HOLD);
   localparam logic [HCW-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HCW'(MAX_HOLD - 1) : '0;
   localparam bit HOLD_EN = (MAX_HOLD != 0);

   state_e           state_q, state_nx;
   logic [IDX_W-1:0] idx_q, idx_nx;
   logic [IDX_W-1:0] ptr_q, ptr_nx;
   logic [HCW-1:0]   hcnt_q, hcnt_nx;
   logic             to_q, to_nx;
   logic             rel_done, rel_drop, rel_hold;
   logic             gnt_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         ptr_q   <= '0;
         hcnt_q  <= '0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_nx;
         idx_q   <= idx_nx;
         ptr_q   <= ptr_nx;
         hcnt_q  <= hcnt_nx;
         to_q    <= to_nx;
      end
   end

   always_comb begin
      state_nx = state_q;
      idx_nx   = idx_q;
      ptr_nx   = ptr_q;
      hcnt_nx  = hcnt_q;
      to_nx    = 1'b0;
      rel_done = 1'b0;
      rel_drop = 1'b0;
      rel_hold = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (|bus.req) begin
               state_nx = ST_GRANT;
               idx_nx   = rr_pick(bus.req, ptr_q);
               hcnt_nx  = '0;
            end
         end
         ST_GRANT: begin
            rel_done = bus.done;
            rel_drop = ~bus.req[idx_q];
            rel_hold = HOLD_EN && (hcnt_q == HOLD_LAST);
            if (rel_done || rel_drop || rel_hold) begin
               state_nx = ST_IDLE;
               idx_nx   = '0;
               ptr_nx   = idx_q + IDX_W'(1);
               hcnt_nx  = '0;
               // Timeout only reports a release the limit alone forced.
               to_nx    = rel_hold && !rel_done && !rel_drop;
            end else if (hcnt_q != HOLD_LAST) begin
               hcnt_nx = hcnt_q + HCW'(1);
            end
         end
         default: begin
            state_nx = ST_IDLE;
            idx_nx   = '0;
         end
      endcase
   end

   assign gnt_valid     = (state_q == ST_GRANT);
   assign bus.gnt_valid = gnt_valid;
   assign bus.gnt_idx   = idx_q;
   assign bus.timeout   = to_q;

   rr_arbiter_4_decoder_2x4 u_dec (
      .idx    (idx_q),
      .en     (gnt_valid),
      .onehot (bus.gnt_onehot)
   );

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Testbench for rr_arbiter_4: directed scenarios followed by a random phase,
// every cycle compared against a cycle-count reference model.
module tb_rr_arbiter_4;

   localparam int MH = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   rr_arbiter_4_if bus();

   rr_arbiter_4 #(.MAX_HOLD(MH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model: whether a grant is held, by whom, for how many cycles
   // so far, and the agent that gets first look at the next arbitration.
   bit m_busy;
   int m_idx;
   int m_ptr;
   int m_held;
   bit m_to;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic predict();
      bit found;
      int c;
      m_to = 1'b0;
      if (rst) begin
         m_busy = 0; m_idx = 0; m_ptr = 0; m_held = 0;
      end else if (!m_busy) begin
         found = 0;
         for (int i = 0; i < 4; i++) begin
            c = (m_ptr + i) % 4;
            if (!found && bus.req[c]) begin
               found = 1; m_idx = c;
            end
         end
         if (found) begin
            m_busy = 1; m_held = 1;
         end
      end else begin
         if (bus.done || !bus.req[m_idx] || (MH != 0 && m_held == MH)) begin
            m_to   = (MH != 0 && m_held == MH) && !bus.done && bus.req[m_idx];
            m_busy = 0;
            m_ptr  = (m_idx + 1) % 4;
            m_idx  = 0;
         end else begin
            m_held++;
         end
      end
   endtask

   // Advance one clock and compare every output with the model.
   task automatic cyc();
      int oh;
      predict();
      @(posedge clk);
      #1;
      oh = m_busy ? (1 << m_idx) : 0;
      chk("valid",   8'(bus.gnt_valid),  8'(m_busy));
      chk("idx",     8'(bus.gnt_idx),    8'(m_idx));
      chk("onehot",  8'(bus.gnt_onehot), 8'(oh));
      chk("timeout", 8'(bus.timeout),    8'(m_to));
   endtask

   initial begin
      rst = 1'b1; bus.req = 4'b0000; bus.done = 1'b0;

      // 1: reset state, then 0101 -> idx 0, done, idle, idx 2
      cyc();
      chk("t1_rst_valid",  8'(bus.gnt_valid), 8'd0);
      chk("t1_rst_onehot", 8'(bus.gnt_onehot), 8'd0);
      rst = 1'b0; bus.req = 4'b0101;
      cyc();
      chk("t1_idx0",   8'(bus.gnt_idx),    8'd0);
      chk("t1_oh0",    8'(bus.gnt_onehot), 8'b0001);
      bus.done = 1'b1; cyc();
      chk("t1_rel",    8'(bus.gnt_valid),  8'd0);
      bus.done = 1'b0; cyc();
      chk("t1_idx2",   8'(bus.gnt_idx),    8'd2);
      chk("t1_oh2",    8'(bus.gnt_onehot), 8'b0100);
      bus.done = 1'b1; cyc();
      bus.done = 1'b0;

      // 2: all requesting, order 0,1,2,3,0 from reset
      rst = 1'b1; cyc(); rst = 1'b0;
      bus.req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         cyc();
         chk("t2_order", 8'(bus.gnt_idx), 8'(k % 4));
         bus.done = 1'b1; cyc();
         chk("t2_gap", 8'(bus.gnt_valid), 8'd0);
         bus.done = 1'b0;
      end

      // 3: single requester held, hold limit forces release
      bus.req = 4'b0010;
      cyc();
      chk("t3_grant", 8'(bus.gnt_idx), 8'd1);
      for (int k = 0; k < MH - 1; k++) begin
         cyc();
         chk("t3_hold", 8'(bus.gnt_valid), 8'd1);
      end
      cyc();
      chk("t3_rel",     8'(bus.gnt_valid), 8'd0);
      chk("t3_timeout", 8'(bus.timeout),   8'd1);
      cyc();
      chk("t3_regrant", 8'(bus.gnt_valid), 8'd1);
      chk("t3_reidx",   8'(bus.gnt_idx),   8'd1);
      chk("t3_to_clr",  8'(bus.timeout),   8'd0);
      bus.done = 1'b1; cyc(); bus.done = 1'b0;

      // 4: idx 3 drops its request, pointer wraps to 0
      bus.req = 4'b1000; cyc();
      chk("t4_idx3", 8'(bus.gnt_idx), 8'd3);
      bus.req = 4'b0000; cyc();
      chk("t4_rel", 8'(bus.gnt_valid), 8'd0);
      chk("t4_to",  8'(bus.timeout),   8'd0);
      bus.req = 4'b1111; cyc();
      chk("t4_wrap", 8'(bus.gnt_idx), 8'd0);
      bus.done = 1'b1; cyc(); bus.done = 1'b0;

      // 5: reset in the middle of a grant of idx 2
      bus.req = 4'b0100; cyc();
      chk("t5_idx2", 8'(bus.gnt_idx), 8'd2);
      rst = 1'b1; cyc();
      chk("t5_valid", 8'(bus.gnt_valid),  8'd0);
      chk("t5_oh",    8'(bus.gnt_onehot), 8'd0);
      rst = 1'b0; bus.req = 4'b1100; cyc();
      chk("t5_regrant", 8'(bus.gnt_idx), 8'd2);
      bus.done = 1'b1; cyc(); bus.done = 1'b0;

      // 6: done in the cycle the hold limit is reached suppresses timeout
      bus.req = 4'b0001; cyc();
      chk("t6_grant", 8'(bus.gnt_idx), 8'd0);
      for (int k = 0; k < MH - 1; k++) cyc();
      bus.done = 1'b1; cyc();
      chk("t6_rel", 8'(bus.gnt_valid), 8'd0);
      chk("t6_to",  8'(bus.timeout),   8'd0);
      bus.done = 1'b0;

      // Random phase: sticky requests so hold limits are reached too.
      for (int n = 0; n < 800; n++) begin
         if ($urandom_range(0, 3) == 0) bus.req = 4'($urandom_range(0, 15));
         bus.done = ($urandom_range(0, 5) == 0);
         rst      = ($urandom_range(0, 149) == 0);
         cyc();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
